// File: rtl/cba_pkg.sv
// Shared definitions for the carry-bypass serial adder.
//   SLICE_W            : nibble width handled per clock
//   state_e            : controller states
//   slice_bypass_carry : carry select of a carry-bypass slice
package cba_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // A fully propagating slice forwards its carry-in unchanged, so the
  // ripple result is skipped in that case.
  function automatic logic slice_bypass_carry(input logic p,
                                              input logic cin,
                                              input logic ripple_c);
    return p ? cin : ripple_c;
  endfunction

endpackage

// File: rtl/cba_slice4.sv
// Combinational 4-bit carry-bypass adder slice.
//   a4, b4 : slice operands
//   ci     : carry into bit 0 of the slice
//   s4     : slice sum
//   co     : slice carry out (bypass-selected)
//   p      : slice propagate (all bits a^b set)
//   c3     : carry into bit 3 (only with CBA_SERIAL_OVF_EN)
module cba_slice4
  import cba_pkg::*;
(
  input  logic [SLICE_W-1:0] a4,
  input  logic [SLICE_W-1:0] b4,
  input  logic               ci,
  output logic [SLICE_W-1:0] s4,
  output logic               co,
  output logic               p
`ifdef CBA_SERIAL_OVF_EN
  ,
  output logic               c3
`endif
);

  logic [SLICE_W:0] rsum;

  assign rsum = {1'b0, a4} + {1'b0, b4} + {{SLICE_W{1'b0}}, ci};
  assign s4   = rsum[SLICE_W-1:0];
  assign p    = &(a4 ^ b4);
  assign co   = slice_bypass_carry(p, ci, rsum[SLICE_W]);

`ifdef CBA_SERIAL_OVF_EN
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign c3 = s4[SLICE_W-1] ^ a4[SLICE_W-1] ^ b4[SLICE_W-1];
`endif

endmodule

// File: rtl/cba_serial_adder.sv
// Multi-cycle wide adder: one 4-bit carry-bypass slice per clock.
// Optional feature macro: CBA_SERIAL_OVF_EN (adds signed overflow output ovf).
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout[, ovf])
//   busy                 : high while slices are being added
module cba_serial_adder
  import cba_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CBA_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSL   = WIDTH / SLICE_W;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("cba_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [SLICE_W-1:0] slice_s;
  logic               slice_co, slice_p;
  logic               last_slice;

`ifdef CBA_SERIAL_OVF_EN
  logic               slice_c3;
  logic               ovf_q, ovf_d;
`endif

  // Operands are shifted right each cycle, so the active slice is always the low nibble.
  cba_slice4 u_slice (
    .a4 (a_sh_q[SLICE_W-1:0]),
    .b4 (b_sh_q[SLICE_W-1:0]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co),
    .p  (slice_p)
`ifdef CBA_SERIAL_OVF_EN
    ,
    .c3 (slice_c3)
`endif
  );

  assign last_slice = (idx_q == IDX_W'(NSL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CBA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CBA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef CBA_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d  = a_sh_q >> SLICE_W;
        b_sh_d  = b_sh_q >> SLICE_W;
        carry_d = slice_co;
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        if (last_slice) begin
          cout_d  = slice_co;
`ifdef CBA_SERIAL_OVF_EN
          ovf_d   = slice_c3 ^ slice_co;
`endif
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CBA_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Bypass must agree with ripple: a propagating slice passes its carry-in straight out.
  a_bypass_carry : assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_RUN && slice_p) |-> (slice_co == carry_q));

endmodule

// File: tb/tb_cba_serial_adder.sv
module tb_cba_serial_adder;

  localparam int W   = 16;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef CBA_SERIAL_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  cba_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CBA_SERIAL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  bit           stall_en = 1'b0;
  bit           seen = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    exp_t         e;
    logic [W:0]   r;
    r      = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ia[W-1] == ib[W-1]) && (e.sum[W-1] != ia[W-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: compare on the first cycle of each result, then check it stays stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst || !out_valid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      held_sum  = sum;
      held_cout = cout;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
`ifdef CBA_SERIAL_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end else begin
      chk("hold_sum", 32'(sum), 32'(held_sum));
      chk("hold_cout", 32'(cout), 32'(held_cout));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Waits (bounded) for in_ready, driving ignored junk meanwhile, then presents one op.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    e = model(ia, ib, ic);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed operations
    issue(16'h1234, 16'h4321, 1'b0);
    drain();
    issue(16'hFFFF, 16'h0000, 1'b1);
    drain();
    issue(16'h7FFF, 16'h0001, 1'b0);
    drain();
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Backpressure in DONE with ignored new operands
    out_ready = 1'b0;
    issue(16'h1111, 16'h2222, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_reached_done", 32'(out_valid), 32'd1);
    repeat (3) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Reset after two slices have been added
    issue(16'h0F0F, 16'h0F0F, 1'b1);
    @(posedge clk);
    #1;
    chk("run_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'hABCD, 16'h5678, 1'b1);
    drain();

    // Random operations with random output stalls
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();
    stall_en = 1'b0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
